xnor_popcount_seq: RTL and testbench
====================================

Name: xnor_popcount_seq

Overview:
Sequencer that streams a long binary-neuron dot product through one shared XNOR-popcount datapath, one CHUNK_W-bit slice per cycle. It accepts x/w chunks from an upstream buffer over a valid/ready handshake and issues them to the datapath. It tracks in-flight slices across the datapath's fixed pipeline latency, accumulates the per-chunk match counts, and applies a threshold to produce the neuron activation bit. It sits between the activation/weight buffers and the popcount tree in the BNN layer engine.

Parameters:
CHUNK_W, 128, bits per chunk issued to the datapath
CNT_W, 8, width of datapath count result; must hold CHUNK_W
MAX_CHUNKS, 16, maximum chunks per job
PIPE_LAT, 2, cycles from dp_vld to valid dp_cnt; legal range 1..4
ACC_W, 12, accumulator width, CNT_W + log2(MAX_CHUNKS)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  job start pulse, sampled in IDLE only
num_chunks  in  5  chunks in the job, 0..MAX_CHUNKS, latched on start
threshold  in  ACC_W  activation threshold, latched on start
abort  in  1  synchronous job cancel
chunk_valid  in  1  upstream chunk available
chunk_ready  out  1  sequencer accepts chunk
chunk_x  in  CHUNK_W  activation chunk
chunk_w  in  CHUNK_W  weight chunk
dp_vld  out  1  registered issue strobe to datapath
dp_x  out  CHUNK_W  registered activation chunk to datapath
dp_w  out  CHUNK_W  registered weight chunk to datapath
dp_cnt  in  CNT_W  datapath match count, valid PIPE_LAT cycles after dp_vld
busy  out  1  job in progress
done  out  1  one-cycle completion pulse
acc_out  out  ACC_W  final match total, held until next done
act  out  1  acc_out >= threshold, unsigned, held until next done

Behaviour:
- Reset (async, rst=1): FSM to IDLE; all outputs 0, including chunk_ready, dp_x/dp_w, acc_out and act. Pipeline tracker and counters are cleared.
- States: IDLE, FEED, DRAIN, DONE.
- IDLE:
  - start=1 with num_chunks in 1..MAX_CHUNKS: latch num_chunks and threshold, clear acc, go to FEED.
  - start=1 with num_chunks=0: go to DONE with acc=0.
  - num_chunks > MAX_CHUNKS is clamped to MAX_CHUNKS.
- FEED:
  - chunk_ready=1.
  - Each chunk_valid&chunk_ready edge registers chunk_x/chunk_w into dp_x/dp_w, pulses dp_vld for exactly one cycle, and increments the issued counter.
  - The handshake that issues the last chunk moves the FSM to DRAIN.
  - chunk_valid low inserts bubbles: no dp_vld and no state change.
- DRAIN: chunk_ready=0. Exit to DONE once the tracker is empty and the last count has been accumulated.
- DONE:
  - done=1 for one cycle; acc_out and act are updated on that same edge.
  - Next state is IDLE.
  - start is not accepted in DONE.
- busy=1 in FEED, DRAIN and DONE.
- Tracker: a PIPE_LAT-deep shift register of dp_vld. On the edge where its output is 1, acc <= acc + dp_cnt, zero-extended to ACC_W. No saturation is needed; the maximum total, CHUNK_W*MAX_CHUNKS = 2048, fits in ACC_W.
- Timing: the last handshake at edge e gives dp_vld during cycle e+1, accumulation at edge e+1+PIPE_LAT, and done high after edge e+2+PIPE_LAT. Back-to-back jobs carry a one-cycle IDLE gap.
- start while busy: ignored.
- abort=1 in any non-IDLE state:
  - Return to IDLE next edge.
  - Clear the tracker and acc; dp_vld forced 0.
  - No done pulse; acc_out and act keep their previous values.
  - abort in IDLE has no effect. abort wins over start when both are asserted.
- rst mid-job: immediate return to the reset state; in-flight dp_cnt values are discarded.

Decomposition:
- Shared package: FSM state enum, ACC_W derivation function, PIPE_LAT legal-range constants.
- One sub-module: xnor_pop_inflight_tracker, the PIPE_LAT shift register with an empty flag. This makes the latency tracking reusable for other sequencers that share the popcount tree.

Test Plan:
- rst=1 mid-FEED, then released -> all outputs 0, FSM in IDLE, next job computes correctly.
- num_chunks=1, x=w=all ones, threshold=100, chunk_valid held high, PIPE_LAT=2; start at edge 0 -> handshake at edge 1, done after edge 5, acc_out=128, act=1.
- num_chunks=4, dp_cnt values 10/20/30/40, threshold=101, no bubbles -> acc_out=100, act=0, done after edge 8. Repeat with threshold=100 -> act=1.
- num_chunks=4 with chunk_valid low for 2 cycles between chunks 2 and 3 -> exactly 4 dp_vld pulses, acc_out=100, done delayed by 2 cycles.
- num_chunks=0, start -> done one cycle later, acc_out=0; threshold=0 -> act=1. num_chunks=16, all matches -> acc_out=2048, no overflow.
- start pulsed during FEED -> ignored. abort during DRAIN -> no done, dp_vld stays 0, acc_out keeps its prior value, and a new start is accepted the cycle after IDLE is reached.

Source files
------------

// File: rtl/xnor_popcount_seq_pkg.sv
// Shared state encoding, latency limits and width helper for the XNOR-popcount
// sequencer and its in-flight tracker.
package xnor_popcount_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } seq_state_e;

  localparam int PIPE_LAT_MIN = 1;
  localparam int PIPE_LAT_MAX = 4;

  // Accumulator must hold MAX_CHUNKS full-width counts without wrapping.
  function automatic int calc_acc_w(input int cnt_w, input int max_chunks);
    return cnt_w + $clog2(max_chunks);
  endfunction

endpackage

// File: rtl/xnor_pop_inflight_tracker.sv
// Shift register of issue strobes that marks the cycle each datapath result
// arrives, plus an empty flag for drain detection.
module xnor_pop_inflight_tracker
  import xnor_popcount_seq_pkg::*;
#(
  parameter int PIPE_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic in_vld,
  output logic out_vld,
  output logic empty
);

  // Out-of-range latencies are pinned to the nearest supported depth.
  localparam int DEPTH = (PIPE_LAT < PIPE_LAT_MIN) ? PIPE_LAT_MIN :
                         (PIPE_LAT > PIPE_LAT_MAX) ? PIPE_LAT_MAX : PIPE_LAT;

  logic [DEPTH-1:0] sr_q;
  logic [DEPTH-1:0] sr_d;

  always_comb begin
    sr_d = '0;
    if (!clr) begin
      sr_d = DEPTH'({sr_q, in_vld});
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign out_vld = sr_q[DEPTH-1];
  assign empty   = ~|sr_q;

endmodule

// File: rtl/xnor_popcount_seq.sv
// Streams a multi-chunk binary dot product through a shared XNOR-popcount
// datapath, accumulates the match counts and thresholds the total.
module xnor_popcount_seq
  import xnor_popcount_seq_pkg::*;
#(
  parameter int CHUNK_W    = 128,
  parameter int CNT_W      = 8,
  parameter int MAX_CHUNKS = 16,
  parameter int PIPE_LAT   = 2,
  parameter int ACC_W      = calc_acc_w(CNT_W, MAX_CHUNKS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [4:0]         num_chunks,
  input  logic [ACC_W-1:0]   threshold,
  input  logic               abort,
  input  logic               chunk_valid,
  output logic               chunk_ready,
  input  logic [CHUNK_W-1:0] chunk_x,
  input  logic [CHUNK_W-1:0] chunk_w,
  output logic               dp_vld,
  output logic [CHUNK_W-1:0] dp_x,
  output logic [CHUNK_W-1:0] dp_w,
  input  logic [CNT_W-1:0]   dp_cnt,
  output logic               busy,
  output logic               done,
  output logic [ACC_W-1:0]   acc_out,
  output logic               act
);

  seq_state_e         state_q, state_d;
  logic [4:0]         num_q, num_d;
  logic [4:0]         issued_q, issued_d;
  logic [ACC_W-1:0]   thr_q, thr_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               chunk_ready_q, chunk_ready_d;
  logic               dp_vld_q, dp_vld_d;
  logic [CHUNK_W-1:0] dp_x_q, dp_x_d;
  logic [CHUNK_W-1:0] dp_w_q, dp_w_d;
  logic               done_q, done_d;
  logic [ACC_W-1:0]   acc_out_q, acc_out_d;
  logic               act_q, act_d;

  logic               trk_clr;
  logic               trk_out;
  logic               trk_empty;
  logic               handshake;
  logic [4:0]         nc_clamped;

  xnor_pop_inflight_tracker #(
    .PIPE_LAT (PIPE_LAT)
  ) u_tracker (
    .clk     (clk),
    .rst     (rst),
    .clr     (trk_clr),
    .in_vld  (dp_vld_q),
    .out_vld (trk_out),
    .empty   (trk_empty)
  );

  assign nc_clamped = (num_chunks > 5'(MAX_CHUNKS)) ? 5'(MAX_CHUNKS) : num_chunks;
  assign handshake  = (state_q == S_FEED) && chunk_valid && chunk_ready_q && !abort;

  always_comb begin
    state_d       = state_q;
    num_d         = num_q;
    issued_d      = issued_q;
    thr_d         = thr_q;
    acc_d         = acc_q;
    chunk_ready_d = chunk_ready_q;
    dp_vld_d      = 1'b0;
    dp_x_d        = dp_x_q;
    dp_w_d        = dp_w_q;
    done_d        = 1'b0;
    acc_out_d     = acc_out_q;
    act_d         = act_q;
    trk_clr       = 1'b0;

    if (trk_out) begin
      acc_d = acc_q + ACC_W'(dp_cnt);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_d    = nc_clamped;
          thr_d    = threshold;
          acc_d    = '0;
          issued_d = '0;
          if (nc_clamped == 5'd0) begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            acc_out_d = '0;
            act_d     = (threshold == '0);
          end else begin
            state_d       = S_FEED;
            chunk_ready_d = 1'b1;
          end
        end
      end
      S_FEED: begin
        if (handshake) begin
          dp_x_d   = chunk_x;
          dp_w_d   = chunk_w;
          dp_vld_d = 1'b1;
          issued_d = issued_q + 5'd1;
          if (issued_q + 5'd1 == num_q) begin
            state_d       = S_DRAIN;
            chunk_ready_d = 1'b0;
          end
        end
      end
      // The final count lands in acc_q on the edge the tracker drains empty.
      S_DRAIN: begin
        if (!dp_vld_q && trk_empty) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          acc_out_d = acc_q;
          act_d     = (acc_q >= thr_q);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d       = S_IDLE;
      chunk_ready_d = 1'b0;
      dp_vld_d      = 1'b0;
      acc_d         = '0;
      issued_d      = '0;
      done_d        = 1'b0;
      acc_out_d     = acc_out_q;
      act_d         = act_q;
      trk_clr       = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      num_q         <= '0;
      issued_q      <= '0;
      thr_q         <= '0;
      acc_q         <= '0;
      chunk_ready_q <= 1'b0;
      dp_vld_q      <= 1'b0;
      dp_x_q        <= '0;
      dp_w_q        <= '0;
      done_q        <= 1'b0;
      acc_out_q     <= '0;
      act_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      num_q         <= num_d;
      issued_q      <= issued_d;
      thr_q         <= thr_d;
      acc_q         <= acc_d;
      chunk_ready_q <= chunk_ready_d;
      dp_vld_q      <= dp_vld_d;
      dp_x_q        <= dp_x_d;
      dp_w_q        <= dp_w_d;
      done_q        <= done_d;
      acc_out_q     <= acc_out_d;
      act_q         <= act_d;
    end
  end

  assign chunk_ready = chunk_ready_q;
  assign dp_vld      = dp_vld_q;
  assign dp_x        = dp_x_q;
  assign dp_w        = dp_w_q;
  assign done        = done_q;
  assign acc_out     = acc_out_q;
  assign act         = act_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_xnor_popcount_seq.sv
// Randomized directed bench for xnor_popcount_seq with a behavioural datapath
// and a job-level reference of match totals, activation and completion time.
module tb_xnor_popcount_seq;

  localparam int CHUNK_W    = 128;
  localparam int CNT_W      = 8;
  localparam int MAX_CHUNKS = 16;
  localparam int PIPE_LAT   = 2;
  localparam int ACC_W      = 12;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [4:0]         num_chunks;
  logic [ACC_W-1:0]   threshold;
  logic               abort;
  logic               chunk_valid;
  logic               chunk_ready;
  logic [CHUNK_W-1:0] chunk_x;
  logic [CHUNK_W-1:0] chunk_w;
  logic               dp_vld;
  logic [CHUNK_W-1:0] dp_x;
  logic [CHUNK_W-1:0] dp_w;
  logic [CNT_W-1:0]   dp_cnt;
  logic               busy;
  logic               done;
  logic [ACC_W-1:0]   acc_out;
  logic               act;

  int n_cmp = 0;
  int n_err = 0;
  int edge_cnt = 0;
  int vld_pulses = 0;
  int cnt_plan [16];
  logic [CHUNK_W-1:0] exp_x_q [$];
  logic [CHUNK_W-1:0] exp_w_q [$];

  logic             pipe_vld [PIPE_LAT] = '{default: 1'b0};
  logic [CNT_W-1:0] pipe_cnt [PIPE_LAT] = '{default: '0};
  logic [CNT_W-1:0] junk_cnt = '0;

  always #5 clk = ~clk;

  xnor_popcount_seq #(
    .CHUNK_W    (CHUNK_W),
    .CNT_W      (CNT_W),
    .MAX_CHUNKS (MAX_CHUNKS),
    .PIPE_LAT   (PIPE_LAT),
    .ACC_W      (ACC_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_chunks  (num_chunks),
    .threshold   (threshold),
    .abort       (abort),
    .chunk_valid (chunk_valid),
    .chunk_ready (chunk_ready),
    .chunk_x     (chunk_x),
    .chunk_w     (chunk_w),
    .dp_vld      (dp_vld),
    .dp_x        (dp_x),
    .dp_w        (dp_w),
    .dp_cnt      (dp_cnt),
    .busy        (busy),
    .done        (done),
    .acc_out     (acc_out),
    .act         (act)
  );

  function automatic int match_count(input logic [CHUNK_W-1:0] x, input logic [CHUNK_W-1:0] w);
    int c;
    c = 0;
    for (int i = 0; i < CHUNK_W; i++) begin
      if (x[i] == w[i]) c++;
    end
    return c;
  endfunction

  function automatic logic [CHUNK_W-1:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check_val(input string tag, input logic [CHUNK_W-1:0] obs, input logic [CHUNK_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Shared popcount tree: result appears PIPE_LAT cycles after the issue strobe, junk otherwise.
  always @(posedge clk) begin
    edge_cnt    <= edge_cnt + 1;
    junk_cnt    <= CNT_W'($urandom);
    pipe_vld[0] <= dp_vld;
    pipe_cnt[0] <= CNT_W'(match_count(dp_x, dp_w));
    for (int i = 1; i < PIPE_LAT; i++) begin
      pipe_vld[i] <= pipe_vld[i-1];
      pipe_cnt[i] <= pipe_cnt[i-1];
    end
  end
  assign dp_cnt = pipe_vld[PIPE_LAT-1] ? pipe_cnt[PIPE_LAT-1] : junk_cnt;

  always @(negedge clk) begin
    if (!rst && dp_vld) begin
      vld_pulses++;
      if (exp_x_q.size() == 0) begin
        check_val("dp_vld_unexpected", dp_vld, 1'b0);
      end else begin
        check_val("dp_x", dp_x, exp_x_q.pop_front());
        check_val("dp_w", dp_w, exp_w_q.pop_front());
      end
    end
  end

  task automatic feed_plain(input int n);
    int issued;
    int guard;
    logic [CHUNK_W-1:0] x;
    logic [CHUNK_W-1:0] w;
    issued = 0;
    guard  = 0;
    while (issued < n && guard < 100) begin
      x = rand128();
      w = rand128();
      chunk_x = x;
      chunk_w = w;
      chunk_valid = 1'b1;
      if (chunk_ready) begin
        exp_x_q.push_back(x);
        exp_w_q.push_back(w);
        issued++;
      end
      @(negedge clk);
      guard++;
    end
    chunk_valid = 1'b0;
    check_val("feed_plain_count", issued, n);
  endtask

  // Called at a negedge; mode 0 random data, 1 all-ones, 2 match counts from cnt_plan.
  task automatic run_job(input int n, input int thr, input int mode, input int bubble_pct,
                         input int gap_after, input bit glitch, output int done_rel);
    int exp_n, exp_acc, issued, start_edge, last_hs, exp_done, guard, gap_left, pulses0, k;
    bit gap_done, v;
    logic [CHUNK_W-1:0] x;
    logic [CHUNK_W-1:0] w;
    logic [CHUNK_W-1:0] m;
    exp_n    = (n > MAX_CHUNKS) ? MAX_CHUNKS : n;
    exp_acc  = 0;
    issued   = 0;
    guard    = 0;
    gap_left = 0;
    gap_done = 1'b0;
    pulses0  = vld_pulses;
    start      = 1'b1;
    num_chunks = 5'(n);
    threshold  = ACC_W'(thr);
    start_edge = edge_cnt + 1;
    last_hs    = start_edge;
    @(negedge clk);
    start      = 1'b0;
    num_chunks = 5'($urandom);
    threshold  = ACC_W'($urandom);
    check_val("busy_after_start", busy, 1'b1);
    if (exp_n > 0) check_val("ready_in_feed", chunk_ready, 1'b1);

    while (issued < exp_n && guard < 400) begin
      if (gap_after >= 0 && issued == gap_after && !gap_done) begin
        gap_left = 2;
        gap_done = 1'b1;
      end
      if (gap_left > 0) begin
        v = 1'b0;
        gap_left--;
      end else begin
        v = ($urandom_range(99) >= bubble_pct);
      end
      x = rand128();
      w = rand128();
      if (mode == 1) begin
        x = '1;
        w = '1;
      end else if (mode == 2) begin
        k = cnt_plan[issued];
        m = (CHUNK_W'(1) << k) - CHUNK_W'(1);
        w = x ^ ~m;
      end
      chunk_x     = x;
      chunk_w     = w;
      chunk_valid = v;
      start       = glitch && (issued == 1);
      if (v && chunk_ready) begin
        exp_acc += match_count(x, w);
        exp_x_q.push_back(x);
        exp_w_q.push_back(w);
        issued++;
        last_hs = edge_cnt + 1;
      end
      @(negedge clk);
      guard++;
    end
    start = 1'b0;
    check_val("feed_complete", issued, exp_n);

    exp_done = (exp_n == 0) ? start_edge : last_hs + 2 + PIPE_LAT;
    guard = 0;
    while (!done && guard < 60) begin
      chunk_valid = 1'($urandom_range(1));
      @(negedge clk);
      guard++;
    end
    chunk_valid = 1'b0;
    check_val("done_seen", done, 1'b1);
    done_rel = edge_cnt - start_edge;
    check_val("done_time", edge_cnt, exp_done);
    check_val("acc_out", acc_out, exp_acc);
    check_val("act", act, exp_acc >= thr);
    check_val("dp_vld_pulses", vld_pulses - pulses0, exp_n);
    @(negedge clk);
    check_val("done_one_cycle", done, 1'b0);
    check_val("idle_after_done", busy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rel;
    int p0;
    logic [ACC_W-1:0] prev_acc;
    logic prev_act;

    rst = 1'b1;
    start = 1'b0;
    num_chunks = '0;
    threshold = '0;
    abort = 1'b0;
    chunk_valid = 1'b0;
    chunk_x = '0;
    chunk_w = '0;
    #12;
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_ready", chunk_ready, 1'b0);
    check_val("rst_dp_vld", dp_vld, 1'b0);
    check_val("rst_dp_x", dp_x, '0);
    check_val("rst_done", done, 1'b0);
    check_val("rst_acc_out", acc_out, '0);
    check_val("rst_act", act, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_job(1, 100, 1, 0, -1, 1'b0, rel);
    check_val("single_latency", rel, 5);
    check_val("single_acc", acc_out, 128);

    cnt_plan[0] = 10; cnt_plan[1] = 20; cnt_plan[2] = 30; cnt_plan[3] = 40;
    run_job(4, 101, 2, 0, -1, 1'b0, rel);
    check_val("four_latency", rel, 8);
    check_val("four_acc", acc_out, 100);
    check_val("four_act_thr101", act, 1'b0);
    run_job(4, 100, 2, 0, -1, 1'b0, rel);
    check_val("four_act_thr100", act, 1'b1);
    run_job(4, 100, 2, 0, 2, 1'b0, rel);
    check_val("gap_latency", rel, 10);
    check_val("gap_acc", acc_out, 100);

    run_job(0, 0, 0, 0, -1, 1'b0, rel);
    check_val("zero_latency", rel, 0);
    check_val("zero_act_thr0", act, 1'b1);
    run_job(0, 5, 0, 0, -1, 1'b0, rel);
    check_val("zero_act_thr5", act, 1'b0);
    run_job(16, 2048, 1, 0, -1, 1'b0, rel);
    check_val("full_acc", acc_out, 2048);
    run_job(20, 2000, 1, 20, -1, 1'b0, rel);
    check_val("clamped_acc", acc_out, 2048);

    run_job(5, 300, 0, 0, -1, 1'b1, rel);

    for (int j = 0; j < 10; j++) begin
      run_job($urandom_range(16, 1), $urandom_range(1100), 0, 25, -1, 1'b0, rel);
    end

    // Abort while draining: no done, outputs hold, next start accepted right away.
    prev_acc = acc_out;
    prev_act = act;
    p0 = vld_pulses;
    start = 1'b1;
    num_chunks = 5'd4;
    threshold = '0;
    @(negedge clk);
    start = 1'b0;
    feed_plain(4);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_val("abort_busy", busy, 1'b0);
    check_val("abort_dp_vld", dp_vld, 1'b0);
    check_val("abort_no_done", done, 1'b0);
    check_val("abort_acc_hold", acc_out, prev_acc);
    check_val("abort_act_hold", act, prev_act);
    check_val("abort_pulses", vld_pulses - p0, 4);
    run_job(6, 350, 0, 10, -1, 1'b0, rel);

    // Asynchronous reset in the middle of a feed.
    start = 1'b1;
    num_chunks = 5'd6;
    threshold = 12'd50;
    @(negedge clk);
    start = 1'b0;
    feed_plain(3);
    #2 rst = 1'b1;
    #1;
    check_val("midrst_busy", busy, 1'b0);
    check_val("midrst_ready", chunk_ready, 1'b0);
    check_val("midrst_dp_vld", dp_vld, 1'b0);
    check_val("midrst_dp_w", dp_w, '0);
    check_val("midrst_acc_out", acc_out, '0);
    check_val("midrst_act", act, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    exp_x_q.delete();
    exp_w_q.delete();
    run_job(5, 320, 0, 20, -1, 1'b0, rel);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
